// File: rtl/lambda_peak_finder_pkg.sv
// Shared types for the lambda peak finder: the lambda sample type and the FSM state enum.
package lambda_peak_finder_pkg;

    localparam int LAMBDA_W    = 14;
    localparam int LAMBDA_FRAC = 8;

    // Signed Q6.8 lambda sample
    typedef logic signed [LAMBDA_W-1:0] lambda_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        REPORT = 2'd2
    } peak_state_e;

endpackage

// File: rtl/lambda_peak_finder_max.sv
// lambda_max_tracker: running maximum of a window with its first index.
// The first sample after clear always loads; afterwards only a strictly larger
// sample replaces the best, so ties keep the earliest index. The next-state
// values are exported so the parent can capture the final result on the same
// edge that accepts the last sample.
module lambda_max_tracker
    import lambda_peak_finder_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_en,
    input  lambda_t          sample_val,
    input  logic [IDX_W-1:0] sample_idx,
    output lambda_t          best_val_nxt,
    output logic [IDX_W-1:0] best_idx_nxt
);

    lambda_t          best_val_q, best_val_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             first_flag_q, first_flag_d;

    // Compare and load: first sample of a window or a strictly greater value wins
    always_comb begin
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        first_flag_d = first_flag_q;
        if (clear) begin
            first_flag_d = 1'b1;
        end else if (sample_en) begin
            if (first_flag_q || (sample_val > best_val_q)) begin
                best_val_d = sample_val;
                best_idx_d = sample_idx;
            end
            first_flag_d = 1'b0;
        end
    end

    // Best-value registers
    always_ff @(posedge clk) begin
        if (rst) begin
            best_val_q   <= '0;
            best_idx_q   <= '0;
            first_flag_q <= 1'b0;
        end else begin
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            first_flag_q <= first_flag_d;
        end
    end

    assign best_val_nxt = best_val_d;
    assign best_idx_nxt = best_idx_d;

endmodule

// File: rtl/lambda_peak_finder.sv
// lambda_peak_finder: finds the maximum lambda and its sample index over a
// window of WIN_LEN valid samples armed by frame_start.
// Optional threshold on the reported peak: define LAMBDA_PEAK_THRESH_EN.
// Without it, peak_found is simply 1 with every report.
module lambda_peak_finder
    import lambda_peak_finder_pkg::*;
#(
    parameter int WIN_LEN = 256,
    parameter int IDX_W   = $clog2(WIN_LEN)
`ifdef LAMBDA_PEAK_THRESH_EN
   ,parameter lambda_t PEAK_THRESH = 14'sd0
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             lambda_valid,
    input  lambda_t          lambda_in,
    output logic             peak_valid,
    output logic             peak_found,
    output logic [IDX_W-1:0] peak_idx,
    output lambda_t          peak_val,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

    peak_state_e      state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic             peak_valid_q, peak_valid_d;
    logic             peak_found_q, peak_found_d;
    logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
    lambda_t          peak_val_q, peak_val_d;

    logic             trk_clear;
    logic             trk_sample;
    logic             last_accept;
    lambda_t          trk_val_nxt;
    logic [IDX_W-1:0] trk_idx_nxt;

    lambda_max_tracker #(.IDX_W(IDX_W)) u_max (
        .clk          (clk),
        .rst          (rst),
        .clear        (trk_clear),
        .sample_en    (trk_sample),
        .sample_val   (lambda_in),
        .sample_idx   (count_q),
        .best_val_nxt (trk_val_nxt),
        .best_idx_nxt (trk_idx_nxt)
    );

    // Next-state and window counter; a frame_start cycle never counts a sample
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        trk_clear   = 1'b0;
        trk_sample  = 1'b0;
        last_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = SEARCH;
                    count_d   = '0;
                    trk_clear = 1'b1;
                end
            end
            SEARCH: begin
                if (frame_start) begin
                    count_d   = '0;
                    trk_clear = 1'b1;
                end else if (lambda_valid) begin
                    trk_sample = 1'b1;
                    if (count_q == LAST_IDX) begin
                        last_accept = 1'b1;
                        count_d     = '0;
                        state_d     = REPORT;
                    end else begin
                        count_d = count_q + IDX_W'(1);
                    end
                end
            end
            REPORT: begin
                if (frame_start) begin
                    state_d   = SEARCH;
                    count_d   = '0;
                    trk_clear = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result capture on the last accepted sample so the fields are registered in REPORT
    always_comb begin
        peak_valid_d = last_accept;
        peak_val_d   = peak_val_q;
        peak_idx_d   = peak_idx_q;
        peak_found_d = peak_found_q;
        if (last_accept) begin
            peak_val_d = trk_val_nxt;
            peak_idx_d = trk_idx_nxt;
`ifdef LAMBDA_PEAK_THRESH_EN
            peak_found_d = (trk_val_nxt >= PEAK_THRESH);
`else
            peak_found_d = 1'b1;
`endif
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            peak_valid_q <= 1'b0;
            peak_found_q <= 1'b0;
            peak_idx_q   <= '0;
            peak_val_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            peak_valid_q <= peak_valid_d;
            peak_found_q <= peak_found_d;
            peak_idx_q   <= peak_idx_d;
            peak_val_q   <= peak_val_d;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_found = peak_found_q;
    assign peak_idx   = peak_idx_q;
    assign peak_val   = peak_val_q;
    assign busy       = (state_q == SEARCH);

endmodule
